uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receive module.
- Captures each received character and its parity-error flag on the receiver's one-cycle done pulse.
- Stores entries in a first-word-fall-through FIFO and presents them to the host/register interface through a pop handshake.
- Provides level, full/empty, threshold-interrupt and sticky overrun/underflow status.

---
 rtl/uart_rx_fifo.sv | 103 ++++++++++
 tb/tb_uart_rx_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer between the UART receiver and the host interface.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             synchronous flush of contents and status
//   rx_done_i           one-cycle character-valid pulse from the receiver
//   rx_parity_error_i   parity flag sampled with rx_done_i
//   rx_data_i           character sampled with rx_done_i
//   rd_en_i             pop the head entry
//   thresh_i            level interrupt threshold (0 disables)
//   overrun_clr_i       clear the sticky overrun flag
//   rd_data_o           head character, 0 when empty
//   rd_parity_err_o     parity flag of the head character, 0 when empty
//   empty_o, full_o     level == 0 / level == DEPTH
//   level_o             entry count 0..DEPTH
//   level_irq_o         thresh_i != 0 && level_o >= thresh_i
//   overrun_o           sticky: character dropped while full
//   underflow_o         sticky: pop attempted while empty
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  rx_done_i,
    input  logic                  rx_parity_error_i,
    input  logic [DATA_WIDTH-1:0] rx_data_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2:0]   thresh_i,
    input  logic                  overrun_clr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_parity_err_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  level_irq_o,
    output logic                  overrun_o,
    output logic                  underflow_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overrun;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_level_nxt;
    logic [DATA_WIDTH:0]   w_head;

    always_comb begin
        w_empty     = r_level == '0;
        w_full      = r_level == LVL_FULL;
        w_pop       = rd_en_i && !w_empty;
        // a pop in the same cycle frees the slot a full FIFO needs
        w_push      = rx_done_i && (!w_full || w_pop);
        w_drop      = rx_done_i && w_full && !w_pop;
        w_level_nxt = (w_push && !w_pop) ? r_level + LVL_ONE :
                      (w_pop && !w_push) ? r_level - LVL_ONE : r_level;
        w_head      = w_empty ? '0 : r_mem[r_rptr];
    end

    // storage is deliberately left unreset; only the pointers qualify it
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && w_push)
            r_mem[r_wptr] <= {rx_parity_error_i, rx_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overrun   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wptr      <= w_push ? r_wptr + PTR_ONE : r_wptr;
            r_rptr      <= w_pop ? r_rptr + PTR_ONE : r_rptr;
            r_level     <= w_level_nxt;
            // a new drop outranks a same-cycle clear request
            r_overrun   <= w_drop || (r_overrun && !overrun_clr_i);
            r_underflow <= r_underflow || (rd_en_i && w_empty);
        end
    end

    assign rd_data_o       = w_head[DATA_WIDTH-1:0];
    assign rd_parity_err_o = w_head[DATA_WIDTH];
    assign empty_o         = w_empty;
    assign full_o          = w_full;
    assign level_o         = r_level;
    assign level_irq_o     = (thresh_i != '0) && (r_level >= thresh_i);
    assign overrun_o       = r_overrun;
    assign underflow_o     = r_underflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table-driven and sequence checks for uart_rx_fifo.
module tb_uart_rx_fifo;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clear_i = 1'b0;
    logic       rx_done_i = 1'b0;
    logic       rx_parity_error_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rd_en_i = 1'b0;
    logic [4:0] thresh_i = '0;
    logic       overrun_clr_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_parity_err_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] level_o;
    logic       level_irq_o;
    logic       overrun_o;
    logic       underflow_o;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .rx_done_i(rx_done_i), .rx_parity_error_i(rx_parity_error_i),
        .rx_data_i(rx_data_i), .rd_en_i(rd_en_i), .thresh_i(thresh_i),
        .overrun_clr_i(overrun_clr_i), .rd_data_o(rd_data_o),
        .rd_parity_err_o(rd_parity_err_o), .empty_o(empty_o), .full_o(full_o),
        .level_o(level_o), .level_irq_o(level_irq_o), .overrun_o(overrun_o),
        .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       done;
        logic [7:0] d;
        logic       p;
        logic       rd;
        logic       clr;
        logic [4:0] th;
        logic [4:0] lvl;
        logic       e;
        logic       f;
        logic [7:0] q;
        logic       qp;
        logic       ov;
        logic       uf;
        logic       irq;
    } vec_t;

    vec_t v [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic done, input logic [7:0] d, input logic p,
                       input logic rd, input logic clr, input logic oc);
        rx_done_i = done;
        rx_data_i = d;
        rx_parity_error_i = p;
        rd_en_i = rd;
        clear_i = clr;
        overrun_clr_i = oc;
        @(posedge clk_i);
        #1;
        rx_done_i = 1'b0;
        rd_en_i = 1'b0;
        clear_i = 1'b0;
        overrun_clr_i = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //          done d      p     rd    clr   th     lvl    e     f     q      qp    ov    uf    irq
        v[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0};
        v[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
        v[3]  = '{1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0};
        v[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0};
        v[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[6]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 5'd4, 5'd1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        v[7]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 5'd4, 5'd2, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        v[8]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 5'd4, 5'd3, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        v[9]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 5'd4, 5'd4, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
        v[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd4, 5'd3, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        v[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
        v[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        v[13] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
        v[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0};
        v[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
        v[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        v[17] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0};
        v[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0};
        v[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("reset_state", {level_o, empty_o, full_o, rd_data_o, rd_parity_err_o, overrun_o, underflow_o, level_irq_o},
            {5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

        for (int i = 0; i < 20; i++) begin
            thresh_i = v[i].th;
            cyc(v[i].done, v[i].d, v[i].p, v[i].rd, v[i].clr, 1'b0);
            chk($sformatf("vec%0d lvl_e_f_q_qp_ov_uf_irq", i),
                {level_o, empty_o, full_o, rd_data_o, rd_parity_err_o, overrun_o, underflow_o, level_irq_o},
                {v[i].lvl, v[i].e, v[i].f, v[i].q, v[i].qp, v[i].ov, v[i].uf, v[i].irq});
        end
        thresh_i = '0;

        fill(16);
        chk("fill16 lvl_f_e_q_ov", {level_o, full_o, empty_o, rd_data_o, overrun_o}, {5'd16, 1'b1, 1'b0, 8'h00, 1'b0});
        cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("overflow lvl_f_ov", {level_o, full_o, overrun_o}, {5'd16, 1'b1, 1'b1});
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_order%0d", i), rd_data_o, 8'(i));
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("drained e_q_ov", {empty_o, rd_data_o, overrun_o}, {1'b1, 8'h00, 1'b1});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("overrun_clr", overrun_o, 1'b0);

        fill(16);
        cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("overrun_set_wins lvl_ov", {level_o, overrun_o}, {5'd16, 1'b1});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("overrun_clr2", overrun_o, 1'b0);

        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("full_wr_pop lvl_f_ov_q", {level_o, full_o, overrun_o, rd_data_o}, {5'd16, 1'b1, 1'b0, 8'h01});
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("full_wr_pop_order%0d", i), rd_data_o, 8'(i));
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("last_is_55", rd_data_o, 8'h55);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("after_55 e_lvl", {empty_o, level_o}, {1'b1, 5'd0});

        fill(16);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lvl5 lvl_ov_q", {level_o, overrun_o, rd_data_o}, {5'd5, 1'b1, 8'h0B});
        cyc(1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("clear lvl_e_ov_uf_q", {level_o, empty_o, overrun_o, underflow_o, rd_data_o},
            {5'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("underflow lvl_uf", {level_o, underflow_o}, {5'd0, 1'b1});
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("underflow_sticky", underflow_o, 1'b1);

        fill(2);
        rst_i = 1'b1;
        cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        chk("reset_midstream lvl_e_uf_q", {level_o, empty_o, underflow_o, rd_data_o}, {5'd0, 1'b1, 1'b0, 8'h00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
